// File: rtl/read_req_gen_if.sv
// Read handshake between the frame read request generator and the DDR3 read
// controller: the request level, the selected bank and the two replies.
interface read_req_gen_if;
  logic       read_req;
  logic       read_req_ack;
  logic [1:0] read_addr_index;
  logic       read_frame_done;

  // Request generator side.
  modport master (
    output read_req,
    output read_addr_index,
    input  read_req_ack,
    input  read_frame_done
  );

  // DDR3 read controller side.
  modport slave (
    input  read_req,
    input  read_addr_index,
    output read_req_ack,
    output read_frame_done
  );
endinterface

// File: rtl/read_req_gen.sv
// Display-side frame read request generator. Each rising edge of video_vsync
// requests the newest completed write bank, or re-reads the previous bank when
// no new frame has arrived. The request is held until it is acknowledged or
// times out, and the frame is then tracked until the reader reports it done.
module read_req_gen #(
  parameter int BANK_NUM    = 3,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           video_vsync,
  input  logic           wr_frame_done,
  input  logic [1:0]     wr_done_index,
  read_req_gen_if.master rd,
  output logic           frame_repeat,
  output logic           frame_overrun,
  output logic           ack_timeout
);

  localparam logic [2:0]  BANK_LIM = 3'(BANK_NUM);
  localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_e;

  state_e      state, state_nx;
  logic        vs_d0, vs_d1;
  logic [1:0]  latest_idx, latest_idx_nx;
  logic        latest_valid, latest_valid_nx;
  logic        fresh, fresh_nx;
  logic        sel_new, sel_new_nx;   // current request picked a new bank
  logic [15:0] to_cnt, to_cnt_nx;
  logic        req_q, req_nx;
  logic [1:0]  idx_q, idx_nx;
  logic        repeat_nx, overrun_nx, timeout_nx;
  logic        frame_start;
  logic        wr_ok;

  assign frame_start = vs_d0 & ~vs_d1;
  // Indices at or beyond BANK_NUM are discarded without touching the tracker.
  assign wr_ok       = wr_frame_done && ({1'b0, wr_done_index} < BANK_LIM);

  assign rd.read_req        = req_q;
  assign rd.read_addr_index = idx_q;

  // Next-state, tracker and registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_nx        = state;
    latest_idx_nx   = latest_idx;
    latest_valid_nx = latest_valid;
    fresh_nx        = fresh;
    sel_new_nx      = sel_new;
    to_cnt_nx       = to_cnt;
    req_nx          = req_q;
    idx_nx          = idx_q;
    repeat_nx       = 1'b0;
    overrun_nx      = 1'b0;
    timeout_nx      = 1'b0;

    // Only the newest completed frame is remembered.
    if (wr_ok) begin
      latest_idx_nx   = wr_done_index;
      latest_valid_nx = 1'b1;
      fresh_nx        = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (frame_start && (latest_valid || wr_ok)) begin
          req_nx    = 1'b1;
          to_cnt_nx = '0;
          state_nx  = REQ;
          if (fresh || wr_ok) begin
            // A same-cycle write bypasses straight into the read index.
            idx_nx     = wr_ok ? wr_done_index : latest_idx;
            fresh_nx   = 1'b0;
            sel_new_nx = 1'b1;
          end else begin
            repeat_nx  = 1'b1;
            sel_new_nx = 1'b0;
          end
        end
      end
      REQ: begin
        overrun_nx = frame_start;
        if (rd.read_req_ack) begin
          req_nx   = 1'b0;
          state_nx = ACTIVE;
        end else if (to_cnt == TO_LAST) begin
          req_nx     = 1'b0;
          timeout_nx = 1'b1;
          state_nx   = IDLE;
          // An abandoned new bank is still unread, so offer it again.
          if (sel_new) fresh_nx = 1'b1;
        end else begin
          to_cnt_nx = to_cnt + 16'd1;
        end
      end
      ACTIVE: begin
        overrun_nx = frame_start;
        if (rd.read_frame_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, vsync edge detector and registered outputs.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state         <= IDLE;
      vs_d0         <= 1'b0;
      vs_d1         <= 1'b0;
      latest_idx    <= '0;
      latest_valid  <= 1'b0;
      fresh         <= 1'b0;
      sel_new       <= 1'b0;
      to_cnt        <= '0;
      req_q         <= 1'b0;
      idx_q         <= '0;
      frame_repeat  <= 1'b0;
      frame_overrun <= 1'b0;
      ack_timeout   <= 1'b0;
    end else begin
      state         <= state_nx;
      vs_d0         <= video_vsync;
      vs_d1         <= vs_d0;
      latest_idx    <= latest_idx_nx;
      latest_valid  <= latest_valid_nx;
      fresh         <= fresh_nx;
      sel_new       <= sel_new_nx;
      to_cnt        <= to_cnt_nx;
      req_q         <= req_nx;
      idx_q         <= idx_nx;
      frame_repeat  <= repeat_nx;
      frame_overrun <= overrun_nx;
      ack_timeout   <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_read_req_gen.sv
// Scoreboard bench for read_req_gen: stimulus pushes the events it expects
// (request rise with bank, repeat, overrun, timeout pulses) and a negedge
// monitor pops and compares each event the DUT shows.
module tb_read_req_gen;

  typedef enum int {EV_REQ, EV_REPEAT, EV_OVERRUN, EV_TIMEOUT} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [1:0] idx;
  } ev_t;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       video_vsync = 1'b0;
  logic       wr_frame_done = 1'b0;
  logic [1:0] wr_done_index = '0;
  logic       frame_repeat, frame_overrun, ack_timeout;

  read_req_gen_if rd_bus ();

  read_req_gen #(.BANK_NUM(3), .ACK_TIMEOUT(8)) dut (
    .pclk          (pclk),
    .rst           (rst),
    .video_vsync   (video_vsync),
    .wr_frame_done (wr_frame_done),
    .wr_done_index (wr_done_index),
    .rd            (rd_bus),
    .frame_repeat  (frame_repeat),
    .frame_overrun (frame_overrun),
    .ack_timeout   (ack_timeout)
  );

  always #5 pclk = ~pclk;

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];
  logic prev_req = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input logic [1:0] idx);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e kind, input logic [1:0] idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d idx %0d, expected none (t=%0t)",
               int'(kind), idx, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(kind), int'(e.kind));
      if (e.kind == EV_REQ && kind == EV_REQ)
        check("req_index", int'(idx), int'(e.idx));
    end
  endtask

  // Monitor: sample away from the active edge and compare against the queue.
  always @(negedge pclk) begin
    if (!rst) begin
      if (rd_bus.read_req && !prev_req) observe(EV_REQ, rd_bus.read_addr_index);
      if (frame_repeat)  observe(EV_REPEAT, 2'd0);
      if (frame_overrun) observe(EV_OVERRUN, 2'd0);
      if (ack_timeout)   observe(EV_TIMEOUT, 2'd0);
    end
    prev_req = rd_bus.read_req;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Rise at edge k; returns just after edge k+1, when the request is visible.
  task automatic vsync_pulse();
    video_vsync = 1'b1;
    tick(2);
    video_vsync = 1'b0;
  endtask

  task automatic wr_done(input logic [1:0] idx);
    wr_frame_done = 1'b1;
    wr_done_index = idx;
    tick(1);
    wr_frame_done = 1'b0;
  endtask

  task automatic pulse_ack();
    rd_bus.read_req_ack = 1'b1;
    tick(1);
    rd_bus.read_req_ack = 1'b0;
  endtask

  task automatic pulse_done();
    rd_bus.read_frame_done = 1'b1;
    tick(1);
    rd_bus.read_frame_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_req"}, int'(rd_bus.read_req), 0);
    check({tag, "_addr_index"}, int'(rd_bus.read_addr_index), 0);
    check({tag, "_frame_repeat"}, int'(frame_repeat), 0);
    check({tag, "_frame_overrun"}, int'(frame_overrun), 0);
    check({tag, "_ack_timeout"}, int'(ack_timeout), 0);
  endtask

  initial begin
    int high_cnt;
    rd_bus.read_req_ack    = 1'b0;
    rd_bus.read_frame_done = 1'b0;
    tick(3);
    rst = 1'b0;
    check_reset_outputs("reset");

    // No frame written yet: ten frame starts produce nothing.
    for (int f = 0; f < 10; f++) begin
      vsync_pulse();
      tick(2);
      check("no_write_read_req", int'(rd_bus.read_req), 0);
    end

    // First real frame: bank 2, ack three cycles after the request.
    wr_done(2'd2);
    expect_ev(EV_REQ, 2'd2);
    vsync_pulse();
    check("first_req", int'(rd_bus.read_req), 1);
    check("first_index", int'(rd_bus.read_addr_index), 2);
    tick(2);
    check("req_held_before_ack", int'(rd_bus.read_req), 1);
    pulse_ack();
    check("req_drop_after_ack", int'(rd_bus.read_req), 0);
    pulse_done();

    // Invalid bank index ignored; no new frame so the next one repeats bank 2.
    // The ack is zero-wait (first REQ cycle).
    wr_done(2'd3);
    tick(2);
    expect_ev(EV_REQ, 2'd2);
    expect_ev(EV_REPEAT, 2'd0);
    vsync_pulse();
    check("repeat_index", int'(rd_bus.read_addr_index), 2);
    pulse_ack();
    check("zero_wait_ack_drop", int'(rd_bus.read_req), 0);
    pulse_done();

    // Fresh bank 2 request never acknowledged: held exactly 8 cycles.
    wr_done(2'd2);
    expect_ev(EV_REQ, 2'd2);
    expect_ev(EV_TIMEOUT, 2'd0);
    vsync_pulse();
    high_cnt = 0;
    for (int i = 0; i < 20 && rd_bus.read_req; i++) begin
      high_cnt++;
      tick(1);
    end
    check("timeout_req_cycles", high_cnt, 8);
    tick(2);

    // Abandoned new bank is offered again without a repeat pulse.
    expect_ev(EV_REQ, 2'd2);
    vsync_pulse();
    pulse_ack();

    // Frame start while ACTIVE: overrun, no new request.
    expect_ev(EV_OVERRUN, 2'd0);
    vsync_pulse();
    tick(1);
    check("overrun_no_req", int'(rd_bus.read_req), 0);
    pulse_done();
    tick(2);

    // Same-cycle write of bank 1 and frame start: bypass into the index.
    expect_ev(EV_REQ, 2'd1);
    video_vsync = 1'b1;
    tick(1);
    wr_frame_done = 1'b1;
    wr_done_index = 2'd1;
    tick(1);
    wr_frame_done = 1'b0;
    video_vsync   = 1'b0;
    check("bypass_index", int'(rd_bus.read_addr_index), 1);
    pulse_ack();
    pulse_done();

    // Bypass left fresh clear, so the next frame repeats bank 1.
    expect_ev(EV_REQ, 2'd1);
    expect_ev(EV_REPEAT, 2'd0);
    vsync_pulse();
    check("repeat_after_bypass", int'(rd_bus.read_addr_index), 1);

    // Reset while in REQ clears everything.
    tick(1);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midreq_reset");
    rst = 1'b0;
    tick(2);
    vsync_pulse();
    tick(2);
    check("no_req_after_reset", int'(rd_bus.read_req), 0);

    // Ack arrives in the same cycle as the timeout condition: ack wins.
    wr_done(2'd0);
    expect_ev(EV_REQ, 2'd0);
    vsync_pulse();
    tick(7);
    pulse_ack();
    check("ack_beats_timeout_req", int'(rd_bus.read_req), 0);
    tick(1);
    check("ack_beats_timeout_pulse", int'(ack_timeout), 0);
    pulse_done();

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/read_req_gen.md
# read_req_gen

Display-side frame read request generator for the DDR3 frame buffer. It detects the start of each display frame on `video_vsync` and picks the most recently completed write bank, or repeats the previous bank if no new frame has arrived. It then issues a request/acknowledge handshake to the DDR3 read controller and tracks the frame until the reader reports completion. It is the read-side counterpart of the camera write request generator and sits between the display timing generator and the DDR3 read port arbiter.

## Interface
- `BANK_NUM`, 3: number of frame banks in use, range 2..4; bank indices ≥ BANK_NUM are invalid.
- `ACK_TIMEOUT`, 1023: cycles `read_req` may stay high without ack before it is abandoned; must be ≥ 1 and < 2^16.

- `pclk` in 1: display pixel clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `video_vsync` in 1: display vertical sync, active high, `pclk` domain; the rising edge marks frame start.
- `wr_frame_done` in 1: one-cycle pulse; the writer finished a full frame into bank `wr_done_index`.
- `wr_done_index` in 2: bank written, valid only with `wr_frame_done`.
- `read_req` out 1: level request to the DDR3 read controller; held until ack or timeout.
- `read_req_ack` in 1: read controller accepted the request.
- `read_addr_index` out 2: bank to read; stable from request until the next frame selection.
- `read_frame_done` in 1: one-cycle pulse; the reader finished the current frame.
- `frame_repeat` out 1: one-cycle pulse; this frame re-reads the previous bank.
- `frame_overrun` out 1: one-cycle pulse; a frame start arrived while a read was still outstanding.
- `ack_timeout` out 1: one-cycle pulse; the request was abandoned.

## Operation
- Vsync edge detect: two registers, `vs_d0 <= video_vsync` and `vs_d1 <= vs_d0`. `frame_start = vs_d0 & ~vs_d1`.
- Latest-frame tracker: registers `latest_idx` (2 bits), `latest_valid`, `fresh`.
  - On `wr_frame_done` with `wr_done_index < BANK_NUM`: `latest_idx <= wr_done_index`, `latest_valid <= 1`, `fresh <= 1`.
  - An invalid index is discarded and nothing changes.
- State machine, states IDLE, REQ, ACTIVE:
  - IDLE, on `frame_start`:
    - If `latest_valid` is 0 (no frame written yet): no request, stay IDLE, no pulses.
    - Else if `fresh` (or a valid `wr_frame_done` in the same cycle): `read_addr_index <=` newest index, `fresh <= 0`, `read_req <= 1`, go to REQ.
    - Else: keep `read_addr_index`, pulse `frame_repeat`, `read_req <= 1`, go to REQ.
  - REQ: counter `to_cnt` (16 bits) starts at 0 on entry and increments each cycle.
    - `read_req_ack` = 1: `read_req <= 0`, go to ACTIVE.
    - Otherwise, when `to_cnt == ACK_TIMEOUT-1`: `read_req <= 0`, pulse `ack_timeout`, restore `fresh <= 1` if the bank was newly selected, go to IDLE.
  - ACTIVE: `read_frame_done` = 1 → go to IDLE.
  - `frame_start` in REQ or ACTIVE: pulse `frame_overrun`; no state, index or request change.
- `read_req_ack` is ignored outside REQ. `read_frame_done` is ignored outside ACTIVE.
- The writer may complete frames at any time; only the newest is kept and intermediate frames are dropped silently.

## Timing
- Reset values: `read_req` 0, `read_addr_index` 0, `frame_repeat` 0, `frame_overrun` 0, `ack_timeout` 0, state IDLE, `latest_valid` 0, `fresh` 0, `vs_d0`/`vs_d1` 0, `to_cnt` 0.
- A `rst` pulse mid-handshake drops `read_req` at the same edge and clears all tracking; the next request needs a new `wr_frame_done` followed by a vsync rise.
- Latency:
  - `video_vsync` first sampled high at edge k → `frame_start` true in cycle k..k+1.
  - `read_req`, `read_addr_index` and `frame_repeat` update at edge k+1.
- Ack sampled high at edge m in REQ → `read_req` low after edge m. A zero-wait ack (high in the first REQ cycle) is legal.
- Ack and the timeout condition in the same cycle: the ack wins, with no `ack_timeout` pulse.
- `wr_frame_done` and `frame_start` in the same cycle: the new index bypasses straight into `read_addr_index`, and `fresh` ends at 0.
- `read_frame_done` and `frame_start` in the same cycle while ACTIVE: go to IDLE and pulse `frame_overrun`; this frame is not requested.
- All pulse outputs are registered and exactly one cycle wide.

## Test plan
- Reset, then a vsync rise with no prior `wr_frame_done` → `read_req` stays 0 and no pulses for 10 frames.
- `wr_frame_done` with index 2, then a vsync rise at edge k → `read_req`=1 and `read_addr_index`=2 at k+1. Ack 3 cycles later → `read_req`=0. `read_frame_done` → IDLE.
- Second vsync rise with no new write → `frame_repeat` pulses once and `read_addr_index` stays 2. `wr_done_index`=3 with BANK_NUM=3 → ignored.
- Ack never asserted, ACK_TIMEOUT=8 → `read_req` high exactly 8 cycles, then `ack_timeout` pulses once. The next vsync re-requests bank 2 with no `frame_repeat`.
- Vsync rise while ACTIVE → `frame_overrun` pulses and `read_req` stays 0. Same-cycle `wr_frame_done`(1) + `frame_start` in IDLE → `read_addr_index`=1.
- Assert `rst` while in REQ → `read_req`=0 and all outputs at reset values after that edge.
